// File: rtl/radix4_booth_wallace_mul16.sv
// 16x16 signed/unsigned multiplier: radix-4 Booth recoding, Wallace carry-save
// tree and a final carry-propagate adder, with the 32-bit product registered once.
module radix4_booth_wallace_mul16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        signedFlag,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic [31:0] out
);

    // Bitwise 3:2 counter over whole rows; carries move up one weight and
    // anything that would land at 2^32 falls off the top.
    function automatic logic [31:0] faSum(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [31:0] faCarry(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    logic [17:0] xExt;
    logic [17:0] yExt;
    logic [18:0] yPad;
    logic [31:0] xRow;
    logic [31:0] x2Row;

    // Extending to 18 bits lets the signed Booth datapath handle unsigned operands too.
    assign xExt  = {{2{signedFlag & multiplicand[15]}}, multiplicand};
    assign yExt  = {{2{signedFlag & multiplier[15]}}, multiplier};
    assign yPad  = {yExt, 1'b0};
    assign xRow  = {{14{xExt[17]}}, xExt};
    assign x2Row = xRow << 1;

    // rows[0..8] are the Booth partial products, rows[9] gathers the +1
    // correction bits of every negated partial product.
    logic [31:0] rows [10];

    always_comb begin
        logic [2:0]  triple;
        logic        neg;
        logic [31:0] mag;
        logic [31:0] corrRow;
        corrRow = '0;
        triple  = '0;
        neg     = 1'b0;
        mag     = '0;
        for (int k = 0; k < 10; k++) begin
            rows[k] = '0;
        end
        for (int k = 0; k < 9; k++) begin
            triple = yPad[2*k +: 3];
            neg    = 1'b0;
            mag    = '0;
            case (triple)
                3'b001, 3'b010: mag = xRow;
                3'b011:         mag = x2Row;
                3'b100: begin
                    mag = x2Row;
                    neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    mag = xRow;
                    neg = 1'b1;
                end
                default:        mag = '0;
            endcase
            rows[k]      = (neg ? ~mag : mag) << (2 * k);
            corrRow[2*k] = neg;
        end
        rows[9] = corrRow;
    end

    logic [31:0] s1 [7];
    logic [31:0] s2 [5];
    logic [31:0] s3 [4];
    logic [31:0] s4 [3];
    logic [31:0] sumRow;
    logic [31:0] carryRow;

    // Wallace stages: 10 -> 7 -> 5 -> 4 -> 3 -> 2 rows.
    assign s1[0] = faSum  (rows[0], rows[1], rows[2]);
    assign s1[1] = faCarry(rows[0], rows[1], rows[2]);
    assign s1[2] = faSum  (rows[3], rows[4], rows[5]);
    assign s1[3] = faCarry(rows[3], rows[4], rows[5]);
    assign s1[4] = faSum  (rows[6], rows[7], rows[8]);
    assign s1[5] = faCarry(rows[6], rows[7], rows[8]);
    assign s1[6] = rows[9];

    assign s2[0] = faSum  (s1[0], s1[1], s1[2]);
    assign s2[1] = faCarry(s1[0], s1[1], s1[2]);
    assign s2[2] = faSum  (s1[3], s1[4], s1[5]);
    assign s2[3] = faCarry(s1[3], s1[4], s1[5]);
    assign s2[4] = s1[6];

    assign s3[0] = faSum  (s2[0], s2[1], s2[2]);
    assign s3[1] = faCarry(s2[0], s2[1], s2[2]);
    assign s3[2] = s2[3];
    assign s3[3] = s2[4];

    assign s4[0] = faSum  (s3[0], s3[1], s3[2]);
    assign s4[1] = faCarry(s3[0], s3[1], s3[2]);
    assign s4[2] = s3[3];

    assign sumRow   = faSum  (s4[0], s4[1], s4[2]);
    assign carryRow = faCarry(s4[0], s4[1], s4[2]);

    logic [31:0] productD;
    logic [31:0] productQ;

    assign productD = sumRow + carryRow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            productQ <= '0;
        end else begin
            productQ <= productD;
        end
    end

    assign out = productQ;

endmodule

// File: tb/tb_radix4_booth_wallace_mul16.sv
// Directed and sweep checks of radix4_booth_wallace_mul16 against a plain
// arithmetic reference product.
module tb_radix4_booth_wallace_mul16;

    logic        clk;
    logic        rst;
    logic        signedFlag;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [31:0] out;

    int total;
    int bad;

    radix4_booth_wallace_mul16 dut (
        .clk          (clk),
        .rst          (rst),
        .signedFlag   (signedFlag),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out          (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] refProd(input logic s, input logic [15:0] x,
                                            input logic [15:0] y);
        logic [31:0] xw;
        logic [31:0] yw;
        xw = s ? {{16{x[15]}}, x} : {16'h0000, x};
        yw = s ? {{16{y[15]}}, y} : {16'h0000, y};
        return xw * yw;
    endfunction

    task automatic test_reset();
        rst          = 1'b1;
        signedFlag   = 1'b1;
        multiplicand = 16'h1234;
        multiplier   = 16'h5678;
        @(posedge clk);
        #1;
        total++;
        if (out !== 32'h0000_0000) begin
            bad++;
            $display("[TB] FAIL reset_hold: got %h want %h", out, 32'h0000_0000);
        end
        rst          = 1'b0;
        signedFlag   = 1'b0;
        multiplicand = 16'h0003;
        multiplier   = 16'h0005;
        @(posedge clk);
        #1;
        total++;
        if (out !== 32'h0000_000F) begin
            bad++;
            $display("[TB] FAIL first_after_reset: got %h want %h", out, 32'h0000_000F);
        end
        multiplicand = 16'hFFFF;
        multiplier   = 16'hFFFF;
        @(posedge clk);
        #1;
        total++;
        if (out !== 32'hFFFE_0001) begin
            bad++;
            $display("[TB] FAIL pre_async_reset: got %h want %h", out, 32'hFFFE_0001);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out !== 32'h0000_0000) begin
            bad++;
            $display("[TB] FAIL async_reset: got %h want %h", out, 32'h0000_0000);
        end
        @(posedge clk);
        #1;
        total++;
        if (out !== 32'h0000_0000) begin
            bad++;
            $display("[TB] FAIL reset_held_over_edge: got %h want %h", out, 32'h0000_0000);
        end
        rst = 1'b0;
    endtask

    task automatic test_corners(input logic s, input string tag);
        logic [15:0] xs [4];
        logic [15:0] ys [4];
        logic [31:0] exps [4];
        xs[0] = 16'hFFFF; ys[0] = 16'hFFFF;
        xs[1] = s ? 16'h8000 : 16'hFFFF; ys[1] = s ? 16'h8000 : 16'h0001;
        xs[2] = 16'h8000; ys[2] = s ? 16'h7FFF : 16'h8000;
        xs[3] = s ? 16'hFFFF : 16'h0000; ys[3] = s ? 16'h0002 : 16'hFFFF;
        if (s) begin
            exps[0] = 32'h0000_0001;
            exps[1] = 32'h4000_0000;
            exps[2] = 32'hC000_8000;
            exps[3] = 32'hFFFF_FFFE;
        end else begin
            exps[0] = 32'hFFFE_0001;
            exps[1] = 32'h0000_FFFF;
            exps[2] = 32'h4000_0000;
            exps[3] = 32'h0000_0000;
        end
        for (int i = 0; i < 4; i++) begin
            signedFlag   = s;
            multiplicand = xs[i];
            multiplier   = ys[i];
            @(posedge clk);
            #1;
            total++;
            if (out !== exps[i]) begin
                bad++;
                $display("[TB] FAIL %s_%0d (%h*%h): got %h want %h",
                         tag, i, xs[i], ys[i], out, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expv;
        multiplicand = 16'hFFFF;
        multiplier   = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            signedFlag = i[0];
            expv       = i[0] ? 32'h0000_0001 : 32'hFFFE_0001;
            @(posedge clk);
            #1;
            total++;
            if (out !== expv) begin
                bad++;
                $display("[TB] FAIL mode_toggle_%0d: got %h want %h", i, out, expv);
            end
        end
    endtask

    task automatic test_sweep();
        logic [15:0] vals [34];
        logic [31:0] expv;
        for (int i = 0; i < 33; i++) begin
            vals[i] = 16'(i * 16'h07FF);
        end
        vals[33] = 16'hFFFF;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 34; i++) begin
                for (int j = 0; j < 34; j++) begin
                    signedFlag   = m[0];
                    multiplicand = vals[i];
                    multiplier   = vals[j];
                    expv         = refProd(m[0], vals[i], vals[j]);
                    @(posedge clk);
                    #1;
                    total++;
                    if (out !== expv) begin
                        bad++;
                        $display("[TB] FAIL sweep s=%0d %h*%h: got %h want %h",
                                 m, vals[i], vals[j], out, expv);
                    end
                end
            end
        end
        for (int r = 0; r < 400; r++) begin
            signedFlag   = 1'($urandom_range(0, 1));
            multiplicand = 16'($urandom);
            multiplier   = 16'($urandom);
            expv         = refProd(signedFlag, multiplicand, multiplier);
            @(posedge clk);
            #1;
            total++;
            if (out !== expv) begin
                bad++;
                $display("[TB] FAIL random s=%0d %h*%h: got %h want %h",
                         signedFlag, multiplicand, multiplier, out, expv);
            end
        end
    endtask

    task automatic test_booth_digits();
        logic [15:0] ys [4];
        logic [15:0] xs [3];
        logic [31:0] expv;
        ys[0] = 16'h5555; ys[1] = 16'hAAAA; ys[2] = 16'h3333; ys[3] = 16'hCCCC;
        xs[0] = 16'h7FFF; xs[1] = 16'h8001; xs[2] = 16'h8000;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 4; j++) begin
                    signedFlag   = m[0];
                    multiplicand = xs[i];
                    multiplier   = ys[j];
                    expv         = refProd(m[0], xs[i], ys[j]);
                    @(posedge clk);
                    #1;
                    total++;
                    if (out !== expv) begin
                        bad++;
                        $display("[TB] FAIL booth s=%0d %h*%h: got %h want %h",
                                 m, xs[i], ys[j], out, expv);
                    end
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_corners(1'b0, "unsigned");
        test_corners(1'b1, "signed");
        test_back_to_back();
        test_booth_digits();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
